floo_axis_vc_rx: RTL and testbench

Receive half of the credit-based virtual-channel AXI-Stream NoC link. Accepts AXIS beats from the serial-link side, demultiplexes flits into one FIFO per virtual channel (each FIFO is `NumCredits` deep), and presents them to the local NoC as per-channel valid/ready streams. It tracks the buffer slots freed downstream and offers them back to the local transmitter as credit returns. It also forwards peer credits piggybacked on incoming beats to the local transmitter.

---
 rtl/floo_axis_vc_rx.sv | 193 +++++++++++++++++++
 tb/tb_floo_axis_vc_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/floo_axis_vc_rx.sv
// Receive half of the credit-based virtual-channel AXIS NoC link: per-channel flit FIFOs,
// peer-credit forwarding and round-robin credit return. Option: FLOO_AXIS_VC_RX_FALLTHROUGH_EN.

module floo_axis_vc_rx_chan #(
  parameter int unsigned Depth     = 8,
  parameter int unsigned FlitWidth = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [FlitWidth-1:0] push_data_i,
  input  logic                 pop_ready_i,
  output logic                 valid_o,
  output logic [FlitWidth-1:0] data_o,
  output logic                 pop_o,
  output logic                 ovf_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [FlitWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      rd_ptr, wr_ptr;
  logic [CntW-1:0]      cnt;
  logic                 empty, full, enq, deq;
  logic [FlitWidth-1:0] head;

  assign empty = (cnt == '0);
  assign full  = (cnt == CntW'(Depth));

`ifdef FLOO_AXIS_VC_RX_FALLTHROUGH_EN
  // Empty FIFO: incoming flit is presented directly and skips storage if taken now.
  assign valid_o = !empty || push_i;
  assign head    = empty ? push_data_i : mem[rd_ptr];
  assign pop_o   = valid_o && pop_ready_i;
  assign deq     = pop_o && !empty;
  assign enq     = push_i && !(empty && pop_ready_i) && (!full || deq);
`else
  assign valid_o = !empty;
  assign head    = mem[rd_ptr];
  assign pop_o   = valid_o && pop_ready_i;
  assign deq     = pop_o;
  assign enq     = push_i && (!full || deq);
`endif

  assign ovf_o  = push_i && full && !deq;
  assign data_o = valid_o ? head : '0;

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
      if (deq) rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
      case ({enq, deq})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module floo_axis_vc_rx #(
  parameter int unsigned NumChan    = 2,
  parameter int unsigned NumCredits = 8,
  parameter int unsigned FlitWidth  = 64,
  parameter int unsigned ChIdxW     = $clog2(NumChan),
  parameter int unsigned CredW      = $clog2(NumCredits + 1),
  parameter int unsigned TdataW     = 8 * ((FlitWidth + ChIdxW + 7) / 8)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         axis_tvalid_i,
  input  logic [TdataW-1:0]            axis_tdata_i,
  input  logic [ChIdxW+CredW:0]        axis_tuser_i,
  output logic                         axis_tready_o,
  output logic [NumChan-1:0]           flit_valid_o,
  input  logic [NumChan-1:0]           flit_ready_i,
  output logic [NumChan*FlitWidth-1:0] flit_data_o,
  output logic                         peer_cred_valid_o,
  output logic [ChIdxW-1:0]            peer_cred_chan_o,
  output logic [CredW-1:0]             peer_cred_cnt_o,
  output logic                         ret_valid_o,
  input  logic                         ret_ready_i,
  output logic [ChIdxW-1:0]            ret_chan_o,
  output logic [CredW-1:0]             ret_cnt_o,
  output logic                         err_o
);
  localparam int unsigned UserW = 1 + ChIdxW + CredW;

  logic                             rdy_q, acc, dv, bad_ch;
  logic [ChIdxW-1:0]                dch, cch;
  logic [CredW-1:0]                 ccnt;
  logic [FlitWidth-1:0]             flit;
  logic [NumChan-1:0]               hit, pop, ovf;
  logic [NumChan-1:0][CredW-1:0]    pend_q;
  logic [ChIdxW-1:0]                ptr_q, hold_q, rr_sel, gnt, idx;
  logic                             lock_q, found, any, hs;

  assign axis_tready_o = rdy_q;
  assign acc  = axis_tvalid_i && rdy_q;
  assign dv   = axis_tuser_i[UserW-1];
  assign cch  = axis_tuser_i[CredW +: ChIdxW];
  assign ccnt = axis_tuser_i[CredW-1:0];
  assign dch  = axis_tdata_i[ChIdxW-1:0];
  assign flit = axis_tdata_i[ChIdxW +: FlitWidth];

  if (TdataW > ChIdxW + FlitWidth) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^axis_tdata_i[TdataW-1:ChIdxW+FlitWidth];
  end

  // A data beat whose channel matches no FIFO is a bad channel index.
  assign bad_ch = acc && dv && !(|hit);

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    assign hit[c] = acc && dv && (dch == ChIdxW'(c));
    floo_axis_vc_rx_chan #(
      .Depth    (NumCredits),
      .FlitWidth(FlitWidth)
    ) u_chan (
      .clk        (clk_i),
      .rst        (rst_i),
      .push_i     (hit[c]),
      .push_data_i(flit),
      .pop_ready_i(flit_ready_i[c]),
      .valid_o    (flit_valid_o[c]),
      .data_o     (flit_data_o[c*FlitWidth +: FlitWidth]),
      .pop_o      (pop[c]),
      .ovf_o      (ovf[c])
    );
  end

  // Round-robin pick starting at ptr_q; a pending offer stays locked until taken.
  always_comb begin
    rr_sel = ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NumChan; i++) begin
      idx = ChIdxW'((int'(ptr_q) + i) % NumChan);
      if (!found && pend_q[idx] != '0) begin
        found  = 1'b1;
        rr_sel = idx;
      end
    end
  end

  assign gnt         = lock_q ? hold_q : rr_sel;
  assign any         = |pend_q;
  assign hs          = any && ret_ready_i;
  assign ret_valid_o = any;
  assign ret_chan_o  = any ? gnt : '0;
  assign ret_cnt_o   = any ? pend_q[gnt] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdy_q             <= 1'b0;
      err_o             <= 1'b0;
      peer_cred_valid_o <= 1'b0;
      peer_cred_chan_o  <= '0;
      peer_cred_cnt_o   <= '0;
      pend_q            <= '0;
      ptr_q             <= '0;
      hold_q            <= '0;
      lock_q            <= 1'b0;
    end else begin
      rdy_q             <= 1'b1;
      err_o             <= err_o || bad_ch || (|ovf);
      peer_cred_valid_o <= acc && (ccnt != '0);
      if (acc && (ccnt != '0)) begin
        peer_cred_chan_o <= cch;
        peer_cred_cnt_o  <= ccnt;
      end
      for (int c = 0; c < NumChan; c++) begin
        if (hs && gnt == ChIdxW'(c)) pend_q[c] <= CredW'(pop[c]);
        else                         pend_q[c] <= pend_q[c] + CredW'(pop[c]);
      end
      if (hs) begin
        lock_q <= 1'b0;
        ptr_q  <= (gnt == ChIdxW'(NumChan - 1)) ? '0 : gnt + ChIdxW'(1);
      end else if (any) begin
        lock_q <= 1'b1;
        hold_q <= gnt;
      end
    end
  end
endmodule

// File: tb/tb_floo_axis_vc_rx.sv
// Randomized + directed bench for floo_axis_vc_rx against a queue-based reference model.

module tb_floo_axis_vc_rx;
  localparam int NC = 2, NCR = 8, FW = 64, CIW = 1, CW = 4, TW = 72, UW = 6;
  localparam int PADW = TW - CIW - FW;

  logic              clk = 1'b0, rst;
  logic              tvalid, tready;
  logic [TW-1:0]     tdata;
  logic [UW-1:0]     tuser;
  logic [NC-1:0]     fvalid, fready;
  logic [NC*FW-1:0]  fdata;
  logic              pcv, rv, ret_ready, err;
  logic [CIW-1:0]    pcc, rc;
  logic [CW-1:0]     pcn, rn;

  always #5 clk = ~clk;

  floo_axis_vc_rx #(.NumChan(NC), .NumCredits(NCR), .FlitWidth(FW)) dut (
    .clk_i(clk), .rst_i(rst),
    .axis_tvalid_i(tvalid), .axis_tdata_i(tdata), .axis_tuser_i(tuser), .axis_tready_o(tready),
    .flit_valid_o(fvalid), .flit_ready_i(fready), .flit_data_o(fdata),
    .peer_cred_valid_o(pcv), .peer_cred_chan_o(pcc), .peer_cred_cnt_o(pcn),
    .ret_valid_o(rv), .ret_ready_i(ret_ready), .ret_chan_o(rc), .ret_cnt_o(rn),
    .err_o(err)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: flit queues, pending-credit counts, RR pointer and held grant.
  logic [FW-1:0] mq [NC][$];
  int  mp [NC];
  int  mptr, mheld, mpcc, mpcn;
  bit  merr, mrdy, mpcv;

  function automatic int mgnt();
    if (mheld >= 0) return mheld;
    for (int i = 0; i < NC; i++)
      if (mp[(mptr + i) % NC] != 0) return (mptr + i) % NC;
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin mq[c].delete(); mp[c] = 0; end
    mptr = 0; mheld = -1; merr = 0; mrdy = 0; mpcv = 0; mpcc = 0; mpcn = 0;
  endtask

  task automatic model_edge();
    bit acc, hs;
    bit pop [NC];
    int g, ch;
    acc = tvalid && mrdy;
    g   = mgnt();
    hs  = (g >= 0) && ret_ready;
    for (int c = 0; c < NC; c++) begin
      pop[c] = (mq[c].size() > 0) && fready[c];
      if (pop[c]) void'(mq[c].pop_front());
    end
    if (acc && tuser[UW-1]) begin
      ch = int'(tdata[CIW-1:0]);
      if (ch >= NC || mq[ch].size() >= NCR) merr = 1;
      else mq[ch].push_back(tdata[CIW +: FW]);
    end
    mpcv = acc && (tuser[CW-1:0] != 0);
    if (mpcv) begin mpcc = int'(tuser[CW +: CIW]); mpcn = int'(tuser[CW-1:0]); end
    for (int c = 0; c < NC; c++) begin
      if (hs && c == g) mp[c] = pop[c] ? 1 : 0;
      else              mp[c] = mp[c] + (pop[c] ? 1 : 0);
    end
    if (hs) begin mptr = (g + 1) % NC; mheld = -1; end
    else if (g >= 0) mheld = g;
    mrdy = 1;
  endtask

  task automatic compare_all();
    int g;
    chk("tready", 64'(tready), 64'(mrdy));
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("fvalid%0d", c), 64'(fvalid[c]), 64'(mq[c].size() > 0));
      if (mq[c].size() > 0) chk($sformatf("fdata%0d", c), fdata[c*FW +: FW], mq[c][0]);
    end
    chk("peer_valid", 64'(pcv), 64'(mpcv));
    if (mpcv) begin
      chk("peer_chan", 64'(pcc), 64'(mpcc));
      chk("peer_cnt", 64'(pcn), 64'(mpcn));
    end
    g = mgnt();
    chk("ret_valid", 64'(rv), 64'(g >= 0));
    if (g >= 0) begin
      chk("ret_chan", 64'(rc), 64'(g));
      chk("ret_cnt", 64'(rn), 64'(mp[g]));
    end
    chk("err", 64'(err), 64'(merr));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    compare_all();
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic beat(input bit dv, input int ch, input int cch, input int cnt);
    tvalid = 1'b1;
    tdata[CIW-1:0]       = CIW'(ch);
    tdata[CIW +: FW]     = {$urandom, $urandom};
    tdata[TW-1:CIW+FW]   = PADW'($urandom);
    tuser = {dv, CIW'(cch), CW'(cnt)};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tready"}, 64'(tready), 64'd0);
    chk({tag, "_fvalid"}, 64'(fvalid), 64'd0);
    chk({tag, "_fdata"}, 64'(|fdata), 64'd0);
    chk({tag, "_peer"}, 64'({pcv, pcc, pcn}), 64'd0);
    chk({tag, "_ret"}, 64'({rv, rc, rn}), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    int ch, cnt;
    bit dv;
    rst = 1'b1; tvalid = 1'b0; tdata = '0; tuser = '0; fready = '0; ret_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk("tready_up", 64'(tready), 64'd1);

    // Round-robin: pend0=2, pend1=5, then both served in pointer order.
    repeat (2) begin beat(1, 0, 0, 0); step(); end
    repeat (5) begin beat(1, 1, 0, 0); step(); end
    fready = 2'b11;
    repeat (5) step();
    chk("rr_first_chan", 64'(rc), 64'd0);
    chk("rr_first_cnt", 64'(rn), 64'd2);
    ret_ready = 1'b1;
    step();
    chk("rr_second_chan", 64'(rc), 64'd1);
    chk("rr_second_cnt", 64'(rn), 64'd5);
    step();
    chk("rr_done", 64'(rv), 64'd0);
    ret_ready = 1'b0; fready = 2'b00;
    beat(1, 0, 0, 0); step();
    beat(1, 1, 0, 0); step();
    fready = 2'b11;
    step();
    chk("rr_reload_chan", 64'(rc), 64'd0);
    ret_ready = 1'b1;
    repeat (2) step();
    ret_ready = 1'b0; fready = 2'b00;

    // Credit return of three pops from ch0.
    repeat (3) begin beat(1, 0, 0, 0); step(); end
    fready = 2'b01;
    repeat (3) step();
    chk("cr_valid", 64'(rv), 64'd1);
    chk("cr_chan", 64'(rc), 64'd0);
    chk("cr_cnt", 64'(rn), 64'd3);
    fready = 2'b00; ret_ready = 1'b1;
    step();
    chk("cr_cleared", 64'(rv), 64'd0);
    ret_ready = 1'b0;

    // Piggybacked credit-only beat.
    beat(0, 0, 1, 4); step();
    chk("pig_valid", 64'(pcv), 64'd1);
    chk("pig_chan", 64'(pcc), 64'd1);
    chk("pig_cnt", 64'(pcn), 64'd4);
    chk("pig_nopush", 64'(fvalid), 64'd0);
    step();
    chk("pig_pulse", 64'(pcv), 64'd0);

    // Full FIFO with simultaneous push and pop.
    repeat (8) begin beat(1, 0, 0, 0); step(); end
    beat(1, 0, 0, 0); fready = 2'b01; step();
    chk("fullpop_err", 64'(err), 64'd0);
    chk("fullpop_pend", 64'({rv, rc, rn}), 64'({1'b1, 1'b0, 4'd1}));
    fready = 2'b11; ret_ready = 1'b1;
    repeat (10) step();
    chk("fullpop_drained", 64'(fvalid), 64'd0);
    ret_ready = 1'b0; fready = 2'b00;

    // Random traffic, sender respects credits (occupancy + pending <= NumCredits).
    repeat (600) begin
      if ($urandom_range(0, 3) != 0) begin
        ch  = $urandom_range(0, NC - 1);
        dv  = 1'($urandom_range(0, 1));
        if (mq[ch].size() + mp[ch] >= NCR) dv = 0;
        cnt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NCR)) : 0;
        beat(dv, ch, $urandom_range(0, NC - 1), cnt);
      end
      fready    = NC'($urandom);
      ret_ready = ($urandom_range(0, 2) == 0);
      step();
    end
    fready = 2'b11; ret_ready = 1'b1;
    repeat (20) step();
    fready = 2'b00; ret_ready = 1'b0;

    // Overflow on ch1 and sticky error.
    repeat (8) begin beat(1, 1, 0, 0); step(); end
    chk("fill_noerr", 64'(err), 64'd0);
    beat(1, 1, 0, 0); step();
    chk("ovf_err", 64'(err), 64'd1);
    repeat (2) step();
    chk("err_sticky", 64'(err), 64'd1);

    // Asynchronous reset mid-burst with three flits on ch0.
    repeat (3) begin beat(1, 0, 0, 0); step(); end
    beat(1, 0, 0, 0);
    #2 rst = 1'b1;
    #1 chk_all_zero("midrst");
    model_reset();
    tvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("midrst_hold");
    rst = 1'b0;
    step();
    chk("postrst_tready", 64'(tready), 64'd1);
    chk("postrst_fvalid", 64'(fvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
